pg_seq_multi: RTL and testbench
===============================

Name: pg_seq_multi

Overview:
Multi-domain power-gate sequencer. Drives switch, reset, isolation and clock-enable controls for N_DOM independently requested power domains. Each domain walks an ordered ladder with a programmable dwell per rung. A round-robin arbiter lets only one domain toggle its power switch at a time, to limit inrush. Switch acknowledges are supervised by a timeout with sticky per-domain errors. Sits between the always-on control registers and the domain power switches and isolation cells.

Parameters:
N_DOM, 4, number of power domains (1..16)
DLY_W, 4, width of step_dly
TMO_W, 8, width of ack_timeout and the per-domain timeout counter

Ports:
clk  in  1  system clock, always-on
rst  in  1  synchronous reset, active-high
power_req  in  N_DOM  1 = domain requested on
step_dly  in  DLY_W  dwell per intermediate rung, minus 1
ack_timeout  in  TMO_W  switch-ack timeout in cycles; 0 = disabled
sleep_ack  in  N_DOM  switch status per domain, 1 = off, 0 = on
err_clr  in  N_DOM  single-cycle pulse; clears tmo_err[i]
sleep_send  out  N_DOM  switch command per domain, 1 = off
dom_rst_n  out  N_DOM  domain reset, 0 = held in reset
isolate  out  N_DOM  1 = outputs isolated
clk_en  out  N_DOM  domain clock enable
done  out  N_DOM  domain settled in the requested state
tmo_err  out  N_DOM  sticky ack-timeout flag
busy  out  1  OR over domains of "not in OFF or ON"

Behaviour:
- Per-domain ladder levels and registered outputs (sleep_send / isolate / dom_rst_n / clk_en):
  - OFF: 1/1/0/0
  - PWR: 0/1/0/0
  - RUN_RST: 0/1/1/0
  - OPEN: 0/0/1/0
  - ON: 0/0/1/1
- Transitional states between OFF and PWR:
  - SW_REQ: outputs unchanged from the previous level.
  - SW: sleep_send = target value; other outputs as in PWR.
- Outputs are registered. A level's output values are visible from the same edge that enters the level.
- Moves:
  - Dwell: PWR, RUN_RST and OPEN are each held step_dly+1 cycles. Then one rung up if power_req[i]=1, one rung down if 0.
  - Reversal is allowed at any rung boundary, sampled at the move edge.
  - OFF with req=1, or PWR with req=0 at dwell end: go to SW_REQ. Target is 0 when coming from OFF, 1 when coming from PWR.
  - ON with req=0: go to OPEN on the next edge (clk_en drops).
- Power-down order is therefore clk_en off, isolate on, reset on, switch off. Power-up is the exact reverse.
- Arbiter:
  - Grant is issued only when no domain is in SW. Round-robin among domains in SW_REQ; the pointer restarts at last grant+1.
  - The granted domain enters SW on the next edge.
  - The token is freed on leaving SW. The next grant takes effect the following edge: minimum one idle cycle between switch events.
- SW exit:
  - When sleep_ack[i] == target is sampled, go to PWR if target=0, OFF if target=1.
  - power_req changes during SW are ignored until SW exits.
  - If the request was withdrawn while in SW_REQ (not granted), return to the source level.
- Timeout:
  - The counter clears on SW entry and increments each SW cycle.
  - If ack_timeout != 0 and count == ack_timeout with no match: tmo_err[i] <= 1, domain forced to OFF (all OFF outputs on the same edge), token released.
  - While tmo_err[i]=1 the domain stays in OFF regardless of power_req.
  - err_clr[i] clears the flag next edge; the domain then resumes.
- done[i] (combinational from registered state): (OFF & ~power_req[i] & ~tmo_err[i]) | (ON & power_req[i]).
- Reset (rst=1 at an edge), including mid-sequence:
  - All domains to OFF; outputs 1/1/0/0.
  - tmo_err=0, token free, pointer=0, counters 0.
  - done = ~power_req; busy=0.
  - Takes effect on the first edge with rst=1.
- sleep_ack is treated as synchronous; the integrator provides synchronisers.

Test Plan:
1. N_DOM=1, step_dly=0, ack echoes sleep_send one cycle later, power_req 0→1 before edge E1 → sleep_send=0 at E2, dom_rst_n=1 at E5, isolate=0 at E6, clk_en=1 and done=1 at E7. Dropping power_req then reverses in order: clk_en, isolate, dom_rst_n, then sleep_send=1 after grant; done=1 when OFF is reached.
2. step_dly=3 → each of PWR, RUN_RST and OPEN holds exactly 4 cycles; rung changes are spaced 4 cycles apart.
3. All 4 domains requested on in the same cycle → switch grants go 0,1,2,3. Never two domains in SW at once; each SW entry comes one cycle after the previous SW exit.
4. ack_timeout=5, sleep_ack stuck at 1 → after 5 SW cycles tmo_err=1, domain OFF, done=0, token released to the waiting domain. err_clr pulse with power_req=1 → flag clears and power-up restarts.
5. power_req drops while in RUN_RST → at dwell end the domain goes to PWR, then SW_REQ, then OFF. isolate never reaches 0 and clk_en never reaches 1.
6. rst asserted while domain 2 is in SW and domain 0 is ON → next edge all outputs 1/1/0/0, busy=0, tmo_err=0. After rst deasserts, sequencing resumes from OFF.

Source files
------------

// File: rtl/pg_seq_multi_if.sv
`default_nettype none
// ============================================================================
// Module   : pg_seq_multi_if
// Purpose  : Control/status bundle between the always-on register block and
//            the multi-domain power-gate sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface pg_seq_multi_if #(
  parameter int N_DOM = 4,
  parameter int DLY_W = 4,
  parameter int TMO_W = 8
);
  logic [N_DOM-1:0] power_req;
  logic [DLY_W-1:0] step_dly;
  logic [TMO_W-1:0] ack_timeout;
  logic [N_DOM-1:0] sleep_ack;
  logic [N_DOM-1:0] err_clr;
  logic [N_DOM-1:0] sleep_send;
  logic [N_DOM-1:0] dom_rst_n;
  logic [N_DOM-1:0] isolate;
  logic [N_DOM-1:0] clk_en;
  logic [N_DOM-1:0] done;
  logic [N_DOM-1:0] tmo_err;
  logic             busy;

  // Register block / switch side
  modport master (
    output power_req, step_dly, ack_timeout, sleep_ack, err_clr,
    input  sleep_send, dom_rst_n, isolate, clk_en, done, tmo_err, busy
  );

  // Sequencer side
  modport slave (
    input  power_req, step_dly, ack_timeout, sleep_ack, err_clr,
    output sleep_send, dom_rst_n, isolate, clk_en, done, tmo_err, busy
  );
endinterface
`default_nettype wire

// File: rtl/pg_seq_multi.sv
`default_nettype none
// ============================================================================
// Module   : pg_seq_multi
// Purpose  : Multi-domain power-gate sequencer. Each domain climbs/descends
//            OFF-PWR-RUN_RST-OPEN-ON with a programmable dwell; a round-robin
//            token lets only one domain operate its power switch at a time.
// Revision : 1.0 - initial release
// ============================================================================
module pg_seq_multi #(
  parameter int N_DOM = 4,
  parameter int DLY_W = 4,
  parameter int TMO_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  pg_seq_multi_if.slave bus
);

  localparam int PTR_W = (N_DOM > 1) ? $clog2(N_DOM) : 1;

  localparam logic [2:0] S_OFF   = 3'd0;
  localparam logic [2:0] S_SWREQ = 3'd1;
  localparam logic [2:0] S_SW    = 3'd2;
  localparam logic [2:0] S_PWR   = 3'd3;
  localparam logic [2:0] S_RUN   = 3'd4;
  localparam logic [2:0] S_OPEN  = 3'd5;
  localparam logic [2:0] S_ON    = 3'd6;

  // Output codes: {sleep_send, isolate, dom_rst_n, clk_en}
  localparam logic [3:0] O_OFF  = 4'b1100;
  localparam logic [3:0] O_PWR  = 4'b0100;
  localparam logic [3:0] O_RUN  = 4'b0110;
  localparam logic [3:0] O_OPEN = 4'b0010;
  localparam logic [3:0] O_ON   = 4'b0011;

  logic [N_DOM-1:0]   w_in_sw;
  logic [N_DOM-1:0]   w_cand;
  logic [N_DOM-1:0]   w_busy_v;
  logic [2*N_DOM-1:0] w_dbl;
  logic [N_DOM-1:0]   w_rot;
  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   w_gnt_idx;
  logic               w_gnt_any;

  assign w_dbl = {w_cand, w_cand};
  assign w_rot = w_dbl[r_ptr +: N_DOM];

  // Round-robin pick of the first eligible requester at or after the pointer,
  // only while the switch token is free (no domain in SW).
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    if (w_in_sw == '0) begin
      for (int k = N_DOM - 1; k >= 0; k--) begin
        if (w_rot[k]) begin
          w_gnt_any = 1'b1;
          w_gnt_idx = PTR_W'((int'(r_ptr) + k) % N_DOM);
        end
      end
    end
  end

  // Pointer restarts one past the most recent grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_gnt_any) begin
      r_ptr <= (w_gnt_idx == PTR_W'(N_DOM - 1)) ? '0 : w_gnt_idx + 1'b1;
    end
  end

  assign bus.busy = |w_busy_v;

  for (genvar i = 0; i < N_DOM; i++) begin : g_dom
    logic [2:0]       r_state, w_state_nx;
    logic             r_tgt, w_tgt_nx;
    logic [DLY_W-1:0] r_dwell, w_dwell_nx;
    logic [TMO_W-1:0] r_tcnt, w_tcnt_nx, w_tcnt_inc;
    logic             r_err, w_err_nx;
    logic [3:0]       r_out, w_out_nx;
    logic             w_req, w_dwell_end, w_tmo_hit, w_in_dwell, w_gnt;

    assign w_req       = bus.power_req[i];
    assign w_dwell_end = (r_dwell >= bus.step_dly);
    assign w_tcnt_inc  = r_tcnt + 1'b1;
    assign w_tmo_hit   = (bus.ack_timeout != '0) && (w_tcnt_inc == bus.ack_timeout);
    assign w_in_dwell  = (r_state == S_PWR) || (r_state == S_RUN) || (r_state == S_OPEN);
    assign w_gnt       = w_gnt_any && (w_gnt_idx == PTR_W'(i));

    // A waiting domain is eligible only while its request still points the
    // same way as the pending switch move (target 0 = up, target 1 = down).
    assign w_in_sw[i]  = (r_state == S_SW);
    assign w_cand[i]   = (r_state == S_SWREQ) && (w_req != r_tgt);
    assign w_busy_v[i] = (r_state != S_OFF) && (r_state != S_ON);

    // State and registered outputs.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_state <= S_OFF;
        r_tgt   <= 1'b0;
        r_dwell <= '0;
        r_tcnt  <= '0;
        r_err   <= 1'b0;
        r_out   <= O_OFF;
      end else begin
        r_state <= w_state_nx;
        r_tgt   <= w_tgt_nx;
        r_dwell <= w_dwell_nx;
        r_tcnt  <= w_tcnt_nx;
        r_err   <= w_err_nx;
        r_out   <= w_out_nx;
      end
    end

    // Ladder moves, switch handshake and timeout supervision.
    always_comb begin
      w_state_nx = r_state;
      w_tgt_nx   = r_tgt;
      w_tcnt_nx  = r_tcnt;
      w_err_nx   = r_err & ~bus.err_clr[i];
      case (r_state)
        S_OFF: begin
          if (w_req && !r_err) begin
            w_state_nx = S_SWREQ;
            w_tgt_nx   = 1'b0;
          end
        end
        S_SWREQ: begin
          if (w_req == r_tgt) begin
            w_state_nx = r_tgt ? S_PWR : S_OFF;
          end else if (w_gnt) begin
            w_state_nx = S_SW;
            w_tcnt_nx  = '0;
          end
        end
        S_SW: begin
          if (bus.sleep_ack[i] == r_tgt) begin
            w_state_nx = r_tgt ? S_OFF : S_PWR;
          end else if (w_tmo_hit) begin
            w_state_nx = S_OFF;
            w_err_nx   = 1'b1;
          end else begin
            w_tcnt_nx = w_tcnt_inc;
          end
        end
        S_PWR: begin
          if (w_dwell_end) begin
            if (w_req) begin
              w_state_nx = S_RUN;
            end else begin
              w_state_nx = S_SWREQ;
              w_tgt_nx   = 1'b1;
            end
          end
        end
        S_RUN: begin
          if (w_dwell_end) w_state_nx = w_req ? S_OPEN : S_PWR;
        end
        S_OPEN: begin
          if (w_dwell_end) w_state_nx = w_req ? S_ON : S_RUN;
        end
        S_ON: begin
          if (!w_req) w_state_nx = S_OPEN;
        end
        default: w_state_nx = S_OFF;
      endcase
      w_dwell_nx = (w_in_dwell && (w_state_nx == r_state)) ? r_dwell + 1'b1 : '0;
    end

    // Output levels for the state being entered; SW_REQ keeps whatever the
    // source level drove.
    always_comb begin
      w_out_nx = r_out;
      case (w_state_nx)
        S_OFF:   w_out_nx = O_OFF;
        S_SWREQ: w_out_nx = r_out;
        S_SW:    w_out_nx = {w_tgt_nx, O_PWR[2:0]};
        S_PWR:   w_out_nx = O_PWR;
        S_RUN:   w_out_nx = O_RUN;
        S_OPEN:  w_out_nx = O_OPEN;
        S_ON:    w_out_nx = O_ON;
        default: w_out_nx = O_OFF;
      endcase
    end

    assign bus.sleep_send[i] = r_out[3];
    assign bus.isolate[i]    = r_out[2];
    assign bus.dom_rst_n[i]  = r_out[1];
    assign bus.clk_en[i]     = r_out[0];
    assign bus.tmo_err[i]    = r_err;
    assign bus.done[i]       = ((r_state == S_OFF) && !w_req && !r_err) ||
                               ((r_state == S_ON) && w_req);
  end

endmodule
`default_nettype wire

// File: tb/tb_pg_seq_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_pg_seq_multi
// Purpose  : Self-checking bench for pg_seq_multi: directed scenarios plus a
//            randomized phase, all compared every cycle against a rung-level
//            reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pg_seq_multi;
  localparam int N     = 4;
  localparam int DLY_W = 4;
  localparam int TMO_W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pg_seq_multi_if #(.N_DOM(N), .DLY_W(DLY_W), .TMO_W(TMO_W)) bus ();

  pg_seq_multi #(.N_DOM(N), .DLY_W(DLY_W), .TMO_W(TMO_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: rung 0..4 = OFF, PWR, RUN_RST, OPEN, ON
  int m_rung[N];
  int m_dw[N];
  int m_tc[N];
  bit m_wait[N];
  bit m_sw[N];
  bit m_tgt[N];
  bit m_err[N];
  int m_ptr;

  logic [N-1:0] e_ss, e_iso, e_rstn, e_ce, e_done, e_err, e_bsy;
  logic         e_busy;
  logic [N-1:0] stuck;

  int t_a, t_b, t_c, t_d, t_e, k, idx, n_iso, n_ce;
  int t_sw[N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_rung[i] = 0; m_dw[i] = 0; m_tc[i] = 0;
      m_wait[i] = 0; m_sw[i] = 0; m_tgt[i] = 0; m_err[i] = 0;
    end
    m_ptr = 0;
  endtask

  task automatic model_outs();
    for (int i = 0; i < N; i++) begin
      e_ss[i]   = m_sw[i] ? m_tgt[i] : (m_rung[i] == 0);
      e_iso[i]  = (m_rung[i] < 3);
      e_rstn[i] = (m_rung[i] >= 2);
      e_ce[i]   = (m_rung[i] == 4);
      e_err[i]  = m_err[i];
      e_done[i] = (m_rung[i] == 0 && !m_wait[i] && !m_sw[i] && !bus.power_req[i] && !m_err[i]) ||
                  (m_rung[i] == 4 && bus.power_req[i]);
      e_bsy[i]  = m_wait[i] || m_sw[i] || (m_rung[i] >= 1 && m_rung[i] <= 3);
    end
    e_busy = |e_bsy;
  endtask

  task automatic model_step();
    int g;
    bit any_sw, r, a, c, e0;
    g = -1;
    any_sw = 0;
    for (int i = 0; i < N; i++) any_sw |= m_sw[i];
    if (!any_sw) begin
      for (int j = 0; j < N; j++) begin
        if (g < 0 && m_wait[(m_ptr + j) % N] &&
            (bus.power_req[(m_ptr + j) % N] != m_tgt[(m_ptr + j) % N]))
          g = (m_ptr + j) % N;
      end
    end
    if (g >= 0) m_ptr = (g + 1) % N;
    for (int i = 0; i < N; i++) begin
      r  = bus.power_req[i];
      a  = bus.sleep_ack[i];
      c  = bus.err_clr[i];
      e0 = m_err[i];
      m_err[i] = e0 && !c;
      if (m_sw[i]) begin
        if (a == m_tgt[i]) begin
          m_sw[i] = 0; m_rung[i] = m_tgt[i] ? 0 : 1; m_dw[i] = 0;
        end else begin
          m_tc[i]++;
          if (bus.ack_timeout != 0 && m_tc[i] == int'(bus.ack_timeout)) begin
            m_sw[i] = 0; m_rung[i] = 0; m_err[i] = 1;
          end
        end
      end else if (m_wait[i]) begin
        if (r == m_tgt[i]) begin
          m_wait[i] = 0; m_dw[i] = 0;
        end else if (g == i) begin
          m_wait[i] = 0; m_sw[i] = 1; m_tc[i] = 0;
        end
      end else if (m_rung[i] == 0) begin
        if (r && !e0) begin m_wait[i] = 1; m_tgt[i] = 0; end
      end else if (m_rung[i] == 4) begin
        if (!r) begin m_rung[i] = 3; m_dw[i] = 0; end
      end else if (m_dw[i] >= int'(bus.step_dly)) begin
        m_dw[i] = 0;
        if (r) m_rung[i]++;
        else if (m_rung[i] == 1) begin m_wait[i] = 1; m_tgt[i] = 1; end
        else m_rung[i]--;
      end else begin
        m_dw[i]++;
      end
    end
  endtask

  // One clock: advance the model with the inputs the DUT samples, echo the
  // switch state one cycle late, then compare every output.
  task automatic tick();
    logic [N-1:0] ack_nx;
    model_outs();
    ack_nx = e_ss | stuck;
    if (rst) model_reset(); else model_step();
    @(posedge clk);
    #1;
    cyc++;
    bus.sleep_ack = ack_nx;
    model_outs();
    check("sleep_send", bus.sleep_send, e_ss);
    check("isolate",    bus.isolate,    e_iso);
    check("dom_rst_n",  bus.dom_rst_n,  e_rstn);
    check("clk_en",     bus.clk_en,     e_ce);
    check("done",       bus.done,       e_done);
    check("tmo_err",    bus.tmo_err,    e_err);
    check("busy",       bus.busy,       e_busy);
  endtask

  initial begin
    model_reset();
    rst             = 1'b1;
    stuck           = '0;
    bus.power_req   = '0;
    bus.step_dly    = '0;
    bus.ack_timeout = '0;
    bus.sleep_ack   = '1;
    bus.err_clr     = '0;
    tick();
    tick();
    check("rst_done", bus.done, 4'b1111);
    check("rst_busy", bus.busy, 1'b0);
    rst = 1'b0;

    // Power-up of a single domain with unit dwell
    bus.power_req = 4'b0001;
    t_a = -1; t_b = -1; t_c = -1; t_d = -1; t_e = -1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (t_a < 0 && bus.sleep_send[0] === 1'b0) t_a = e;
      if (t_b < 0 && bus.dom_rst_n[0]  === 1'b1) t_b = e;
      if (t_c < 0 && bus.isolate[0]    === 1'b0) t_c = e;
      if (t_d < 0 && bus.clk_en[0]     === 1'b1) t_d = e;
      if (t_e < 0 && bus.done[0]       === 1'b1) t_e = e;
    end
    check("up_sleep_send_edge", t_a, 2);
    check("up_rst_n_edge",      t_b, 5);
    check("up_isolate_edge",    t_c, 6);
    check("up_clk_en_edge",     t_d, 7);
    check("up_done_edge",       t_e, 7);

    // Power-down of the same domain
    bus.power_req = 4'b0000;
    t_a = -1; t_b = -1; t_c = -1; t_d = -1; t_e = -1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (t_a < 0 && bus.clk_en[0]     === 1'b0) t_a = e;
      if (t_b < 0 && bus.isolate[0]    === 1'b1) t_b = e;
      if (t_c < 0 && bus.dom_rst_n[0]  === 1'b0) t_c = e;
      if (t_d < 0 && bus.sleep_send[0] === 1'b1) t_d = e;
      if (t_e < 0 && bus.done[0]       === 1'b1) t_e = e;
    end
    check("dn_clk_en_edge",     t_a, 1);
    check("dn_isolate_edge",    t_b, 2);
    check("dn_rst_n_edge",      t_c, 3);
    check("dn_sleep_send_edge", t_d, 5);
    check("dn_done_edge",       t_e, 7);

    // Dwell of four cycles per intermediate rung
    bus.step_dly  = 4'd3;
    bus.power_req = 4'b0010;
    t_a = -1; t_b = -1; t_c = -1; t_d = -1;
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (t_a < 0 && bus.sleep_send[1] === 1'b0) t_a = e;
      if (t_b < 0 && bus.dom_rst_n[1]  === 1'b1) t_b = e;
      if (t_c < 0 && bus.isolate[1]    === 1'b0) t_c = e;
      if (t_d < 0 && bus.clk_en[1]     === 1'b1) t_d = e;
    end
    check("dwell_sw_edge",   t_a, 2);
    check("dwell_rst_edge",  t_b, 8);
    check("dwell_iso_edge",  t_c, 12);
    check("dwell_clk_edge",  t_d, 16);
    bus.power_req = 4'b0000;
    for (int e = 1; e <= 30; e++) tick();
    check("dwell_off_done", bus.done[1], 1'b1);

    // Simultaneous requests: grants 0,1,2,3 with one idle cycle between
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.step_dly  = 4'd0;
    bus.power_req = 4'b1111;
    for (int i = 0; i < N; i++) t_sw[i] = -1;
    for (int e = 1; e <= 30; e++) begin
      tick();
      for (int i = 0; i < N; i++)
        if (t_sw[i] < 0 && bus.sleep_send[i] === 1'b0) t_sw[i] = e;
    end
    check("rr_sw0", t_sw[0], 2);
    check("rr_sw1", t_sw[1], 5);
    check("rr_sw2", t_sw[2], 8);
    check("rr_sw3", t_sw[3], 11);
    check("rr_all_on", bus.done, 4'b1111);
    bus.power_req = 4'b0000;
    for (int e = 1; e <= 60; e++) tick();
    check("rr_all_off", bus.done, 4'b1111);

    // Ack timeout on domain 3 while domain 2 waits for the token
    bus.ack_timeout = 8'd5;
    stuck = 4'b1000;
    bus.power_req = 4'b1000;
    tick();
    bus.power_req = 4'b1100;
    t_a = -1; t_b = -1; t_c = -1;
    for (int e = 2; e <= 14; e++) begin
      tick();
      if (t_a < 0 && bus.sleep_send[3] === 1'b0) t_a = e;
      if (t_b < 0 && bus.tmo_err[3]    === 1'b1) t_b = e;
      if (t_c < 0 && bus.sleep_send[2] === 1'b0) t_c = e;
    end
    check("tmo_sw_edge",   t_a, 2);
    check("tmo_err_edge",  t_b, 7);
    check("tmo_next_edge", t_c, 8);
    check("tmo_done",      bus.done[3], 1'b0);
    check("tmo_held_off",  bus.sleep_send[3], 1'b1);
    stuck = 4'b0000;
    bus.err_clr = 4'b1000;
    tick();
    bus.err_clr = 4'b0000;
    check("tmo_cleared", bus.tmo_err[3], 1'b0);
    for (int e = 1; e <= 20; e++) tick();
    check("tmo_recovered", bus.done[3], 1'b1);

    // Request withdrawn while in RUN_RST
    bus.ack_timeout = 8'd0;
    bus.step_dly    = 4'd2;
    bus.power_req   = 4'b1101;
    k = 0;
    while (bus.dom_rst_n[0] !== 1'b1 && k < 40) begin tick(); k++; end
    check("wd_reach_run", bus.dom_rst_n[0], 1'b1);
    bus.power_req = 4'b1100;
    n_iso = 0; n_ce = 0;
    for (int e = 1; e <= 30; e++) begin
      tick();
      if (bus.isolate[0] !== 1'b1) n_iso++;
      if (bus.clk_en[0]  !== 1'b0) n_ce++;
    end
    check("wd_iso_never_open", n_iso, 0);
    check("wd_clk_never_on",   n_ce,  0);
    check("wd_off",            bus.sleep_send[0], 1'b1);
    check("wd_done",           bus.done[0], 1'b1);

    // Reset while domain 2 is mid-switch and domain 0 is ON
    bus.step_dly  = 4'd0;
    bus.power_req = 4'b1001;
    for (int e = 1; e <= 20; e++) tick();
    check("rs_dom2_off", bus.done[2], 1'b1);
    check("rs_dom0_on",  bus.clk_en[0], 1'b1);
    stuck = 4'b0100;
    bus.power_req = 4'b1101;
    k = 0;
    while (bus.sleep_send[2] !== 1'b0 && k < 10) begin tick(); k++; end
    check("rs_dom2_sw", bus.sleep_send[2], 1'b0);
    tick();
    rst = 1'b1;
    tick();
    check("rs_ss",   bus.sleep_send, 4'b1111);
    check("rs_iso",  bus.isolate,    4'b1111);
    check("rs_rstn", bus.dom_rst_n,  4'b0000);
    check("rs_ce",   bus.clk_en,     4'b0000);
    check("rs_busy", bus.busy,       1'b0);
    check("rs_err",  bus.tmo_err,    4'b0000);
    check("rs_done", bus.done,       4'b0010);
    rst = 1'b0;
    stuck = 4'b0000;
    for (int e = 1; e <= 40; e++) tick();
    check("rs_resume", bus.done, 4'b1111);

    // Randomized traffic against the model
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.step_dly    = DLY_W'($urandom_range(3));
    bus.ack_timeout = TMO_W'($urandom_range(8, 2));
    for (int e = 0; e < 800; e++) begin
      if ($urandom_range(7) == 0) begin
        idx = $urandom_range(N - 1);
        bus.power_req[idx] = ~bus.power_req[idx];
      end
      if ($urandom_range(39) == 0) begin
        idx = $urandom_range(N - 1);
        stuck[idx] = ~stuck[idx];
      end
      bus.err_clr = ($urandom_range(15) == 0) ? N'($urandom) : '0;
      tick();
    end
    stuck = '0;
    bus.err_clr = '1;
    tick();
    bus.err_clr = '0;
    for (int e = 0; e < 80; e++) tick();
    check("rand_settled", bus.busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
